// File: rtl/pipelined_adder_nbit.sv
// -----------------------------------------------------------------------------
// pipelined_adder_nbit
//
// Purpose
//   N-bit add/subtract unit built from ripple-carry slices spread over S
//   pipeline stages (W = N/S bits per stage). Each operation selects add
//   (a + b + c_in) or subtract (a - b, done as a + ~b + 1). A signed-overflow
//   flag is produced alongside the carry out. Valid/ready handshaking on both
//   sides lets a consumer apply backpressure; the whole pipeline stalls as a
//   unit while the output is held.
//
//   N must be a multiple of S, with 1 <= S <= N.
//
// Parameters
//   N          operand/result width in bits
//   S          number of pipeline stages
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation present on a/b/c_in/sub
//   in_ready   unit accepts an operation this cycle (combinational)
//   a, b       N-bit operands (unsigned or two's complement)
//   c_in       carry-in, used only when sub = 0
//   sub        0: a + b + c_in, 1: a - b
//   out_valid  result present on sum/c_out/ovf
//   out_ready  consumer accepts the result this cycle
//   sum        N-bit result, modulo 2^N
//   c_out      carry out of bit N-1 (for subtract, 1 = no borrow)
//   ovf        signed overflow: carry into bit N-1 XOR carry out of bit N-1
// -----------------------------------------------------------------------------
module pipelined_adder_nbit #(
   parameter int N = 32,
   parameter int S = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         c_out,
   output logic         ovf
);

   localparam int W = N / S;

   logic         advance;
   logic [N-1:0] b_eff;
   logic         cin_eff;

   // The pipeline moves as one: it shifts whenever the output slot is empty
   // or being drained. No bubble collapsing, so a bubble costs a slot.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Subtraction is a + ~b + 1; c_in is ignored in that mode.
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub ? 1'b1 : c_in;

   // Bit-serial ripple across one W-bit slice; returns {carry_out, sum}.
   function automatic logic [W:0] ripple(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic         ci);
      logic         c;
      logic [W-1:0] s;
      c = ci;
      s = '0;
      for (int i = 0; i < W; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c, s};
   endfunction

   for (genvar k = 0; k < S; k++) begin : g_stage
      // Width of the operand bits that later stages still have to sum.
      localparam int REM_W = N - (k + 1) * W;

      logic [W-1:0]         a_sl;
      logic [W-1:0]         b_sl;
      logic                 c_sl;
      logic                 vld_in;
      logic [W:0]           slice;
      logic [(k+1)*W-1:0]   sum_nxt;

      logic                 vld_p;
      logic                 carry_p;
      logic [(k+1)*W-1:0]   sum_p;

      // ---- stage k inputs: from the ports for k = 0, else from stage k-1 ----
      if (k == 0) begin : g_src
         assign a_sl    = a[W-1:0];
         assign b_sl    = b_eff[W-1:0];
         assign c_sl    = cin_eff;
         assign vld_in  = in_valid && in_ready;
         assign slice   = ripple(a_sl, b_sl, c_sl);
         assign sum_nxt = slice[W-1:0];
      end else begin : g_src
         assign a_sl    = g_stage[k-1].g_rem.rem_a_p[W-1:0];
         assign b_sl    = g_stage[k-1].g_rem.rem_b_p[W-1:0];
         assign c_sl    = g_stage[k-1].carry_p;
         assign vld_in  = g_stage[k-1].vld_p;
         assign slice   = ripple(a_sl, b_sl, c_sl);
         // Partial sum grows by one slice per stage, new slice on top.
         assign sum_nxt = {slice[W-1:0], g_stage[k-1].sum_p};
      end

      // ---- stage k register: partial sum, stage carry, valid ----
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_p   <= 1'b0;
            carry_p <= 1'b0;
            sum_p   <= '0;
         end else if (advance) begin
            vld_p   <= vld_in;
            carry_p <= slice[W];
            sum_p   <= sum_nxt;
         end
      end

      if (k < S - 1) begin : g_rem
         // Upper operand slices not yet summed travel with the partial sum;
         // each stage drops the W bits it has just consumed.
         logic [REM_W-1:0] rem_a_nxt;
         logic [REM_W-1:0] rem_b_nxt;
         logic [REM_W-1:0] rem_a_p;
         logic [REM_W-1:0] rem_b_p;

         if (k == 0) begin : g_fwd
            assign rem_a_nxt = a[N-1:W];
            assign rem_b_nxt = b_eff[N-1:W];
         end else begin : g_fwd
            assign rem_a_nxt = g_stage[k-1].g_rem.rem_a_p[REM_W+W-1:W];
            assign rem_b_nxt = g_stage[k-1].g_rem.rem_b_p[REM_W+W-1:W];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rem_a_p <= '0;
               rem_b_p <= '0;
            end else if (advance) begin
               rem_a_p <= rem_a_nxt;
               rem_b_p <= rem_b_nxt;
            end
         end
      end else begin : g_last
         logic c_msb;
         logic ovf_p;

         // Carry into the MSB recovered from the MSB sum bit:
         // s = x ^ y ^ cin  =>  cin = x ^ y ^ s.
         assign c_msb = a_sl[W-1] ^ b_sl[W-1] ^ slice[W-1];

         // ---- final stage: overflow flag registered with the result ----
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_p <= 1'b0;
            end else if (advance) begin
               ovf_p <= c_msb ^ slice[W];
            end
         end

         assign out_valid = vld_p;
         assign sum       = sum_p;
         assign c_out     = carry_p;
         assign ovf       = ovf_p;
      end
   end

endmodule
